quad_step_decoder: RTL

- Upstream stage for the 4-bit up/down counter: turns raw quadrature encoder signals A/B into the counter's en/dir controls.
- Synchronises and glitch-filters A/B, then tracks the Gray-code phase with a small state machine.
- Emits one en_out pulse per legal step, with dir_out giving the direction; flags illegal phase jumps.

---
 rtl/quad_step_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Turns raw quadrature encoder channels A/B into en/dir controls for the
// downstream 4-bit up/down counter. Each channel is synchronised with two
// flops, then glitch-filtered. A small FSM then tracks the Gray-code phase.
//
// Parameters:
//   FILTER_LEN  cycles a synced value must differ from the filtered value
//               before it is accepted (0 = no hold-off), range 0..15
//   CNT_W       width of the per-channel filter counters
//
// Ports:
//   clk         system clock, rising edge
//   arst_n      asynchronous reset, active-low
//   a_in, b_in  encoder channels, asynchronous to clk
//   enable      1 = legal steps pulse en_out; 0 = phase/dir tracked silently
//   err_clr     clears err_sticky (a same-cycle error takes priority)
//   en_out      one-cycle step pulse
//   dir_out     direction of the last legal step (1 = forward/up)
//   err         one-cycle pulse on an illegal (two-bit) phase jump
//   err_sticky  latched error flag
//   err_cnt     saturating error count (only when QDEC_ERR_COUNT_EN is defined)
//   dbg_state   {fsm_in_track, phase[1:0]} for observation
//
// Optional feature: define QDEC_ERR_COUNT_EN to add the err_cnt output.
module quad_step_decoder #(
   parameter int FILTER_LEN = 2,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       enable,
   input  logic       err_clr,
   output logic       en_out,
   output logic       dir_out,
   output logic       err,
   output logic       err_sticky,
`ifdef QDEC_ERR_COUNT_EN
   output logic [7:0] err_cnt,
`endif
   output logic [2:0] dbg_state
);

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] FLEN = CNT_W'(FILTER_LEN);
   // INIT releases one cycle after the first settled filtered value exists:
   // two sync flops, FILTER_LEN hold-off cycles and the filter output flop.
   localparam logic [4:0] INIT_LAST = 5'(3 + FILTER_LEN);

   // Bit 1 carries channel A, bit 0 channel B.
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       filt;
   logic [CNT_W-1:0] fcnt [2];

   state_t     state, state_next;
   logic [1:0] phase, phase_next;
   logic [4:0] init_cnt, init_cnt_next;
   logic       en_next, dir_next, err_next, sticky_next;
   logic [1:0] delta;
   logic [1:0] fwd_target;

   // Synchroniser and filter. The filtered value is always a flop, so with
   // FILTER_LEN=0 it simply follows the synced value one cycle later.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         filt    <= '0;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         sync1 <= {a_in, b_in};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != filt[i]) begin
               if (fcnt[i] == FLEN) begin
                  filt[i] <= sync2[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + CNT_W'(1);
               end
            end else begin
               fcnt[i] <= '0;
            end
         end
      end
   end

   // Next state and outputs.
   always_comb begin
      state_next    = state;
      phase_next    = phase;
      init_cnt_next = init_cnt;
      en_next       = 1'b0;
      dir_next      = dir_out;
      err_next      = 1'b0;
      sticky_next   = err_sticky;
      delta         = filt ^ phase;
      // Forward successor in 00->01->11->10->00.
      fwd_target    = {phase[0], ~phase[1]};

      case (state)
         INIT: begin
            if (init_cnt == INIT_LAST) begin
               state_next    = TRACK;
               phase_next    = filt;
               init_cnt_next = '0;
            end else begin
               init_cnt_next = init_cnt + 5'd1;
            end
         end
         TRACK: begin
            // Phase always follows the input so an illegal jump resyncs.
            phase_next = filt;
            if (delta == 2'b11) begin
               err_next = 1'b1;
            end else if (delta != 2'b00) begin
               en_next  = enable;
               dir_next = (filt == fwd_target);
            end
         end
         default: state_next = INIT;
      endcase

      if (err_next) begin
         sticky_next = 1'b1;
      end else if (err_clr) begin
         sticky_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= INIT;
         phase      <= '0;
         init_cnt   <= '0;
         en_out     <= 1'b0;
         dir_out    <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_next;
         phase      <= phase_next;
         init_cnt   <= init_cnt_next;
         en_out     <= en_next;
         dir_out    <= dir_next;
         err        <= err_next;
         err_sticky <= sticky_next;
      end
   end

`ifdef QDEC_ERR_COUNT_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_cnt <= '0;
      end else if (err_next && err_clr) begin
         err_cnt <= 8'd1;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (err_next && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

   assign dbg_state = {state == TRACK, phase};

endmodule
